// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared types for the instruction-fetch stage.
//   word_t        - 32-bit machine word (PC, instruction)
//   fetch_state_t - fetch FSM states
package fetch_stage_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SQUASH = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_skid_buf.sv
// fetch_skid_buf: 1-entry holding register for an instruction that returned
// from the icache while the IF/DC latch was stalled.
// Only built when FETCH_SKID_EN is defined.
// Ports:
//   CLK, RST            clock, async active-high reset
//   load                capture word_in/npc_in, set valid
//   drain               entry consumed, clear valid
//   clear               discard entry (redirect/halt); wins over load
//   word_in, npc_in     data to capture
//   valid, word, npc    current entry
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  load,
    input  logic  drain,
    input  logic  clear,
    input  word_t word_in,
    input  word_t npc_in,
    output logic  valid,
    output word_t word,
    output word_t npc
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= 1'b0;
            word  <= '0;
            npc   <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            word  <= word_in;
            npc   <= npc_in;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, runs the iREN/ihit
// handshake with the icache and drives the IF/DC latch inputs.
// Optional feature macro: FETCH_SKID_EN (1-entry skid buffer for stalled hits).
// Ports:
//   CLK, RST                 clock, async active-high reset
//   ihit, imemload           icache hit and returned word
//   iREN, imemaddr           icache request and address (always the PC)
//   stall, redirect,
//   redirect_pc, halt        control from hazard unit / MEM / halt detect
//   npc_i1, imemload_i1,
//   id_en, id_flushed        IF/DC latch inputs (combinational from ihit)
//   fetch_busy               a request whose data will be discarded is outstanding
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int unsigned PC_STEP = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic [31:0] npc_i1,
    output logic [31:0] imemload_i1,
    output logic        id_en,
    output logic        id_flushed,
    output logic        fetch_busy
);

    localparam word_t STEP = word_t'(PC_STEP);

    fetch_state_t state, state_n;
    word_t        pc, pc_n, pend_pc, pend_n, pc_inc;

    assign pc_inc   = pc + STEP;   // wraps mod 2^32
    assign imemaddr = pc;

`ifdef FETCH_SKID_EN
    logic  sk_valid, sk_load, sk_drain, sk_clear;
    word_t sk_word, sk_npc;

    fetch_skid_buf u_skid (
        .CLK     (CLK),
        .RST     (RST),
        .load    (sk_load),
        .drain   (sk_drain),
        .clear   (sk_clear),
        .word_in (imemload),
        .npc_in  (pc_inc),
        .valid   (sk_valid),
        .word    (sk_word),
        .npc     (sk_npc)
    );
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= RUN;
            pc      <= PC_INIT;
            pend_pc <= '0;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            pend_pc <= pend_n;
        end
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc;
        pend_n      = pend_pc;
        iREN        = 1'b0;
        id_en       = 1'b0;
        id_flushed  = 1'b0;
        fetch_busy  = 1'b0;
        npc_i1      = '0;
        imemload_i1 = '0;
`ifdef FETCH_SKID_EN
        sk_load     = 1'b0;
        sk_drain    = 1'b0;
        sk_clear    = 1'b0;
`endif
        case (state)
            RUN: begin
                iREN = 1'b1;
`ifdef FETCH_SKID_EN
                // A held word means the PC already moved past it; stop
                // requesting until it has been handed to decode.
                if (sk_valid) iREN = 1'b0;
                if (halt || redirect) sk_clear = 1'b1;
`endif
                if (halt) begin
                    state_n    = HALTED;
                    id_flushed = 1'b1;
                end else if (redirect) begin
                    id_flushed = 1'b1;
`ifdef FETCH_SKID_EN
                    if (ihit || sk_valid) pc_n = redirect_pc;
`else
                    if (ihit) pc_n = redirect_pc;
`endif
                    else begin
                        // Request still in flight: wait for it before moving
                        // the address.
                        pend_n  = redirect_pc;
                        state_n = SQUASH;
                    end
                end else if (stall) begin
`ifdef FETCH_SKID_EN
                    if (!sk_valid && ihit) begin
                        sk_load = 1'b1;
                        pc_n    = pc_inc;
                    end
`endif
`ifdef FETCH_SKID_EN
                end else if (sk_valid) begin
                    id_en       = 1'b1;
                    imemload_i1 = sk_word;
                    npc_i1      = sk_npc;
                    sk_drain    = 1'b1;
`endif
                end else if (ihit) begin
                    id_en       = 1'b1;
                    imemload_i1 = imemload;
                    npc_i1      = pc_inc;
                    pc_n        = pc_inc;
                end
            end
            SQUASH: begin
                iREN       = 1'b1;
                fetch_busy = 1'b1;
                if (halt) begin
                    state_n    = HALTED;
                    id_flushed = 1'b1;
                end else begin
                    if (redirect) begin
                        pend_n     = redirect_pc;
                        id_flushed = 1'b1;
                    end
                    if (ihit) begin
                        pc_n    = redirect ? redirect_pc : pend_pc;
                        state_n = RUN;
                    end
                end
            end
            default: ;  // HALTED: everything idle until reset
        endcase
        // Outputs are forced quiet for as long as reset is held.
        if (RST) begin
            iREN        = 1'b0;
            id_en       = 1'b0;
            id_flushed  = 1'b0;
            fetch_busy  = 1'b0;
            npc_i1      = '0;
            imemload_i1 = '0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

`ifdef FETCH_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        CLK = 1'b0, RST = 1'b1;
    logic        ihit = 1'b0, stall = 1'b0, redirect = 1'b0, halt = 1'b0;
    logic [31:0] imemload = '0, redirect_pc = '0;
    logic        iREN, id_en, id_flushed, fetch_busy;
    logic [31:0] imemaddr, npc_i1, imemload_i1;

    int errors = 0, checks = 0;

    fetch_stage dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .iREN(iREN),
        .imemaddr(imemaddr), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .halt(halt), .npc_i1(npc_i1),
        .imemload_i1(imemload_i1), .id_en(id_en), .id_flushed(id_flushed),
        .fetch_busy(fetch_busy)
    );

    always #5 CLK = ~CLK;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Reference model: mode 0 = fetching, 1 = waiting for a doomed request,
    // 2 = stopped. skid_* models the held instruction.
    int          mode, nx_mode;
    logic [31:0] m_pc, nx_pc, m_pend, nx_pend, skid_w, nx_skid_w, skid_n, nx_skid_n;
    bit          skid_v, nx_skid_v;
    logic        e_iren, e_en, e_fl, e_busy;
    logic [31:0] e_npc, e_word;

    task automatic model_reset();
        mode = 0; m_pc = 32'h0; m_pend = 32'h0; skid_v = 0; skid_w = 0; skid_n = 0;
    endtask

    task automatic model_eval();
        nx_mode = mode; nx_pc = m_pc; nx_pend = m_pend;
        nx_skid_v = skid_v; nx_skid_w = skid_w; nx_skid_n = skid_n;
        e_iren = 0; e_en = 0; e_fl = 0; e_busy = 0; e_npc = 0; e_word = 0;
        if (mode == 0) begin
            e_iren = !skid_v;
            if (halt) begin
                nx_mode = 2; e_fl = 1; nx_skid_v = 0;
            end else if (redirect) begin
                e_fl = 1; nx_skid_v = 0;
                if (ihit || skid_v) nx_pc = redirect_pc;
                else begin nx_pend = redirect_pc; nx_mode = 1; end
            end else if (stall) begin
                if (SKID && !skid_v && ihit) begin
                    nx_skid_v = 1; nx_skid_w = imemload; nx_skid_n = m_pc + 32'd4;
                    nx_pc = m_pc + 32'd4;
                end
            end else if (skid_v) begin
                e_en = 1; e_word = skid_w; e_npc = skid_n; nx_skid_v = 0;
            end else if (ihit) begin
                e_en = 1; e_word = imemload; e_npc = m_pc + 32'd4; nx_pc = m_pc + 32'd4;
            end
        end else if (mode == 1) begin
            e_iren = 1; e_busy = 1;
            if (halt) begin
                nx_mode = 2; e_fl = 1;
            end else begin
                if (redirect) begin nx_pend = redirect_pc; e_fl = 1; end
                if (ihit) begin nx_pc = redirect ? redirect_pc : m_pend; nx_mode = 0; end
            end
        end
    endtask

    task automatic drive(input logic ih, input logic st, input logic rd,
                         input logic [31:0] rpc, input logic hl);
        @(negedge CLK);
        ihit = ih; stall = st; redirect = rd; redirect_pc = rpc; halt = hl;
        imemload = word_at(m_pc);
        #1;
        model_eval();
    endtask

    task automatic advance();
        @(posedge CLK);
        mode = nx_mode; m_pc = nx_pc; m_pend = nx_pend;
        skid_v = nx_skid_v; skid_w = nx_skid_w; skid_n = nx_skid_n;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; ihit = 0; stall = 0; redirect = 0; halt = 0; redirect_pc = 0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
        @(posedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1; ihit = 1; stall = 0; redirect = 0; halt = 0;
        #1;
        checks++;
        if ({iREN, id_en, id_flushed, fetch_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000", {iREN, id_en, id_flushed, fetch_busy});
        end
        checks++;
        if (imemaddr !== 32'h0 || npc_i1 !== 32'h0 || imemload_i1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h npc=%h word=%h want all 0", imemaddr, npc_i1, imemload_i1);
        end
        do_reset();
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0);
            checks++;
            if (imemaddr !== 32'(4*i) || id_en !== 1'b1 || iREN !== 1'b1 ||
                npc_i1 !== 32'(4*i+4) || imemload_i1 !== word_at(32'(4*i))) begin
                errors++;
                $display("FAIL seq[%0d]: addr=%h en=%b npc=%h word=%h want addr=%h en=1 npc=%h word=%h",
                         i, imemaddr, id_en, npc_i1, imemload_i1, 32'(4*i), 32'(4*i+4), word_at(32'(4*i)));
            end
            advance();
        end
    endtask

    task automatic test_stall();
        do_reset();
        repeat (2) begin drive(1, 0, 0, 0, 0); advance(); end
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 0);
            checks++;
            if (imemaddr !== 32'h8 || id_en !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d]: addr=%h en=%b want addr=00000008 en=0", i, imemaddr, id_en);
            end
            advance();
        end
        drive(1, 0, 0, 0, 0);
        checks++;
        if (id_en !== 1'b1 || imemload_i1 !== word_at(32'h8) || npc_i1 !== 32'hC) begin
            errors++;
            $display("FAIL stall_release: en=%b word=%h npc=%h want en=1 word=%h npc=0000000c",
                     id_en, imemload_i1, npc_i1, word_at(32'h8));
        end
        advance();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (imemaddr !== 32'hC || id_en !== 1'b0) begin
            errors++;
            $display("FAIL stall_once: addr=%h en=%b want addr=0000000c en=0", imemaddr, id_en);
        end
        advance();
    endtask

    task automatic test_redirect_squash();
        do_reset();
        repeat (4) begin drive(1, 0, 0, 0, 0); advance(); end
        drive(0, 0, 1, 32'h40, 0);
        checks++;
        if (id_flushed !== 1'b1 || id_en !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush: flushed=%b en=%b want 1/0", id_flushed, id_en);
        end
        advance();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (fetch_busy !== 1'b1 || iREN !== 1'b1 || imemaddr !== 32'h10 || id_en !== 1'b0) begin
            errors++;
            $display("FAIL squash_hold: busy=%b iren=%b addr=%h en=%b want 1/1/00000010/0",
                     fetch_busy, iREN, imemaddr, id_en);
        end
        advance();
        drive(1, 0, 0, 0, 0);
        checks++;
        if (id_en !== 1'b0 || imemaddr !== 32'h10) begin
            errors++;
            $display("FAIL squash_discard: en=%b addr=%h want 0/00000010", id_en, imemaddr);
        end
        advance();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (imemaddr !== 32'h40 || fetch_busy !== 1'b0) begin
            errors++;
            $display("FAIL squash_target: addr=%h busy=%b want 00000040/0", imemaddr, fetch_busy);
        end
        advance();
    endtask

    task automatic test_halt();
        logic [31:0] addr_h;
        do_reset();
        repeat (3) begin drive(1, 0, 0, 0, 0); advance(); end
        addr_h = m_pc;
        drive(1, 0, 1, 32'h80, 1);
        checks++;
        if (id_flushed !== 1'b1 || id_en !== 1'b0) begin
            errors++;
            $display("FAIL halt_edge: flushed=%b en=%b want 1/0", id_flushed, id_en);
        end
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 1'($urandom), 1, 32'h100, 0);
            checks++;
            if (iREN !== 1'b0 || id_en !== 1'b0 || id_flushed !== 1'b0 || imemaddr !== addr_h) begin
                errors++;
                $display("FAIL halted[%0d]: iren=%b en=%b fl=%b addr=%h want 0/0/0/%h",
                         i, iREN, id_en, id_flushed, imemaddr, addr_h);
            end
            advance();
        end
        do_reset();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (imemaddr !== 32'h0 || iREN !== 1'b1) begin
            errors++;
            $display("FAIL halt_rst: addr=%h iren=%b want 00000000/1", imemaddr, iREN);
        end
        advance();
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1, 0, 1, 32'hFFFF_FFFC, 0);
        advance();
        drive(1, 0, 0, 0, 0);
        checks++;
        if (imemaddr !== 32'hFFFF_FFFC || id_en !== 1'b1 || npc_i1 !== 32'h0) begin
            errors++;
            $display("FAIL wrap_npc: addr=%h en=%b npc=%h want fffffffc/1/00000000", imemaddr, id_en, npc_i1);
        end
        advance();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (imemaddr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_pc: addr=%h want 00000000", imemaddr);
        end
        advance();
    endtask

`ifdef FETCH_SKID_EN
    task automatic test_skid();
        do_reset();
        drive(1, 0, 1, 32'h20, 0);
        advance();
        drive(1, 1, 0, 0, 0);
        checks++;
        if (id_en !== 1'b0) begin
            errors++;
            $display("FAIL skid_cap: en=%b want 0", id_en);
        end
        advance();
        drive(0, 1, 0, 0, 0);
        checks++;
        if (iREN !== 1'b0 || imemaddr !== 32'h24) begin
            errors++;
            $display("FAIL skid_hold: iren=%b addr=%h want 0/00000024", iREN, imemaddr);
        end
        advance();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (id_en !== 1'b1 || imemload_i1 !== word_at(32'h20) || npc_i1 !== 32'h24) begin
            errors++;
            $display("FAIL skid_drain: en=%b word=%h npc=%h want 1/%h/00000024",
                     id_en, imemload_i1, npc_i1, word_at(32'h20));
        end
        advance();
        drive(0, 0, 0, 0, 0);
        checks++;
        if (iREN !== 1'b1) begin
            errors++;
            $display("FAIL skid_resume: iren=%b want 1", iREN);
        end
        advance();
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rpc;
            if (mode == 2 && $urandom_range(0, 3) == 0) do_reset();
            rpc = {$urandom_range(0, 255), 2'b00} << ($urandom_range(0, 1) * 22);
            drive(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 25),
                  1'($urandom_range(0, 99) < 10), rpc, 1'($urandom_range(0, 199) == 0));
            checks++;
            if (iREN !== e_iren || id_en !== e_en || fetch_busy !== e_busy || imemaddr !== m_pc ||
                (mode != 1 && id_flushed !== e_fl) || (id_en && id_flushed) ||
                (e_en && (npc_i1 !== e_npc || imemload_i1 !== e_word))) begin
                errors++;
                $display("FAIL rand[%0d]: iren=%b en=%b fl=%b busy=%b addr=%h npc=%h word=%h want iren=%b en=%b fl=%b busy=%b addr=%h npc=%h word=%h",
                         i, iREN, id_en, id_flushed, fetch_busy, imemaddr, npc_i1, imemload_i1,
                         e_iren, e_en, e_fl, e_busy, m_pc, e_npc, e_word);
            end
            advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sequential();
        if (!SKID) test_stall();
        test_redirect_squash();
        test_halt();
        test_wrap();
`ifdef FETCH_SKID_EN
        test_skid();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
